// File: rtl/timer_ctrl.sv
// Control stage for the M:SS countdown timer.
// Drives the BCD digits, the alarm and the spinner step/rest controls.
module timer_ctrl #(
    parameter int SEC_DIV  = 50000000,
    parameter int STEP_DIV = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [3:0] min_d,
    output logic [2:0] sec_t,
    output logic [3:0] sec_o,
    output logic       spin_run,
    output logic       spin_reset,
    output logic       alarm,
    output logic       running
);

    localparam int SW = (SEC_DIV > 2) ? $clog2(SEC_DIV) : 1;
    localparam int TW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] SEC_LAST = SW'(SEC_DIV - 1);
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [3:0] btn, sync1, sync2, prev, press;
    logic p_ss, p_clr, p_min, p_sec;

    logic [SW-1:0] sec_cnt, sec_cnt_n;
    logic [TW-1:0] step_cnt, step_cnt_n;
    logic [3:0] min_n, seco_n;
    logic [2:0] sect_n;
    logic [3:0] dec_min, dec_o;
    logic [2:0] dec_t;
    logic dec_zero, time_zero, step_wrap;
    logic spin_n, spin_reset_n;

    assign btn = {btn_sec, btn_min, btn_clr, btn_ss};
    assign press = sync2 & ~prev;
    assign p_ss = press[0];
    assign p_clr = press[1];
    assign p_min = press[2];
    assign p_sec = press[3];

    assign time_zero = (min_d == 4'd0) && (sec_t == 3'd0) && (sec_o == 4'd0);
    assign running = (state == RUN);
    assign alarm = (state == DONE);

    // One-second BCD decrement with borrow through all three digits
    always_comb begin
        dec_min = min_d;
        dec_t = sec_t;
        dec_o = sec_o - 4'd1;
        if (sec_o == 4'd0) begin
            dec_o = 4'd9;
            dec_t = sec_t - 3'd1;
            if (sec_t == 3'd0) begin
                dec_t = 3'd5;
                dec_min = min_d - 4'd1;
            end
        end
        dec_zero = (dec_min == 4'd0) && (dec_t == 3'd0) && (dec_o == 4'd0);
    end

    always_comb begin
        state_n = state;
        min_n = min_d;
        sect_n = sec_t;
        seco_n = sec_o;
        sec_cnt_n = sec_cnt;
        step_cnt_n = step_cnt;
        step_wrap = 1'b0;
        if (p_clr) begin
            state_n = IDLE;
            min_n = 4'd0;
            sect_n = 3'd0;
            seco_n = 4'd0;
            sec_cnt_n = '0;
            step_cnt_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (p_ss) begin
                        if (!time_zero) begin
                            state_n = RUN;
                            sec_cnt_n = '0;
                            step_cnt_n = '0;
                        end
                    end else begin
                        if (p_min)
                            min_n = (min_d == 4'd9) ? 4'd0 : min_d + 4'd1;
                        if (p_sec)
                            sect_n = (sec_t == 3'd5) ? 3'd0 : sec_t + 3'd1;
                    end
                end
                RUN: begin
                    if (p_ss) begin
                        state_n = PAUSE;
                    end else begin
                        if (sec_cnt == SEC_LAST) begin
                            sec_cnt_n = '0;
                            min_n = dec_min;
                            sect_n = dec_t;
                            seco_n = dec_o;
                            if (dec_zero)
                                state_n = DONE;
                        end else begin
                            sec_cnt_n = sec_cnt + 1'b1;
                        end
                        if (step_cnt == STEP_LAST) begin
                            step_cnt_n = '0;
                            step_wrap = 1'b1;
                        end else begin
                            step_cnt_n = step_cnt + 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (p_ss)
                        state_n = RUN;
                end
                DONE: begin
                    if (p_ss)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
        // No step pulse may leak into DONE on the final tick
        spin_n = step_wrap && (state_n == RUN);
        spin_reset_n = (state_n == IDLE) || (state_n == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev <= sync2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            min_d <= 4'd0;
            sec_t <= 3'd0;
            sec_o <= 4'd0;
            sec_cnt <= '0;
            step_cnt <= '0;
            spin_run <= 1'b0;
            spin_reset <= 1'b1;
        end else begin
            state <= state_n;
            min_d <= min_n;
            sec_t <= sect_n;
            sec_o <= seco_n;
            sec_cnt <= sec_cnt_n;
            step_cnt <= step_cnt_n;
            spin_run <= spin_n;
            spin_reset <= spin_reset_n;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with SEC_DIV=10, STEP_DIV=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_timer_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_ss = 1'b0;
    logic btn_clr = 1'b0;
    logic btn_min = 1'b0;
    logic btn_sec = 1'b0;
    logic [3:0] min_d;
    logic [2:0] sec_t;
    logic [3:0] sec_o;
    logic spin_run, spin_reset, alarm, running;

    int n_vec = 0;
    int n_err = 0;

    timer_ctrl #(.SEC_DIV(10), .STEP_DIV(3)) dut (
        .clk(clk),
        .reset(reset),
        .btn_ss(btn_ss),
        .btn_clr(btn_clr),
        .btn_min(btn_min),
        .btn_sec(btn_sec),
        .min_d(min_d),
        .sec_t(sec_t),
        .sec_o(sec_o),
        .spin_run(spin_run),
        .spin_reset(spin_reset),
        .alarm(alarm),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tm();
        return {20'd0, min_d, 1'b0, sec_t, sec_o};
    endfunction

    function automatic logic [31:0] flags();
        return {28'd0, spin_run, spin_reset, alarm, running};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // m = {sec, min, clr, ss}; returns on the falling edge after the action edge
    task automatic press(input logic [3:0] m);
        {btn_sec, btn_min, btn_clr, btn_ss} = m;
        tick(3);
        {btn_sec, btn_min, btn_clr, btn_ss} = 4'b0000;
    endtask

    task automatic press_gap(input logic [3:0] m);
        press(m);
        tick(2);
    endtask

    initial begin
        int pulses;
        int runs;
        tick(2);
        reset = 1'b0;
        // flags = {spin_run, spin_reset, alarm, running}
        chk("rst_time", tm(), 32'h000);
        chk("rst_flags", flags(), 32'b0100);

        // Test 1: set 2:30
        press_gap(4'b0100);
        press_gap(4'b0100);
        press_gap(4'b1000);
        press_gap(4'b1000);
        press_gap(4'b1000);
        chk("t1_time", tm(), 32'h230);
        chk("t1_flags", flags(), 32'b0100);
        repeat (3) press_gap(4'b1000);
        chk("sec_wrap", tm(), 32'h200);
        repeat (8) press_gap(4'b0100);
        chk("min_wrap", tm(), 32'h000);
        press_gap(4'b1100);
        chk("min_sec_both", tm(), 32'h110);
        press_gap(4'b0010);
        chk("clr_idle", tm(), 32'h000);

        // Test 2: start at 0:00 is refused
        press(4'b0001);
        pulses = 0;
        runs = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            pulses += int'(spin_run);
            runs += int'(running);
        end
        chk("t2_pulses", 32'(pulses), 32'd0);
        chk("t2_running", 32'(runs), 32'd0);

        // Test 3: 0:10 runs to DONE
        press_gap(4'b1000);
        chk("t3_set", tm(), 32'h010);
        press(4'b0001);
        chk("t3_run_flags", flags(), 32'b0001);
        pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            if (spin_run !== ((k % 3) == 0)) pulses++;
        end
        chk("t3_step_pattern", 32'(pulses), 32'd0);
        tick(1);
        chk("t3_first_tick", tm(), 32'h009);
        tick(89);
        chk("t3_last_sec", tm(), 32'h001);
        tick(1);
        chk("t3_done_time", tm(), 32'h000);
        chk("t3_done_flags", flags(), 32'b0110);
        press_gap(4'b0001);
        chk("t3_ack_flags", flags(), 32'b0100);

        // Test 4: 1:00 double borrow, pause and resume
        press_gap(4'b0100);
        press(4'b0001);
        tick(10);
        chk("t4_borrow", tm(), 32'h059);
        press(4'b0001);
        chk("t4_pause_flags", flags(), 32'b0000);
        tick(40);
        chk("t4_frozen", tm(), 32'h059);
        chk("t4_frozen_flags", flags(), 32'b0000);
        press(4'b0001);
        chk("t4_resume_flags", flags(), 32'b0001);
        tick(3);
        chk("t4_resume_step", 32'(spin_run), 32'd1);
        tick(4);
        chk("t4_before_tick", tm(), 32'h059);
        tick(1);
        chk("t4_tick", tm(), 32'h058);

        // Test 5: clr beats ss
        press_gap(4'b0011);
        chk("t5_time", tm(), 32'h000);
        chk("t5_flags", flags(), 32'b0100);

        // Test 6: asynchronous reset mid-run, then held button
        press_gap(4'b0100);
        press(4'b0001);
        tick(3);
        chk("t6_pre_flags", flags(), 32'b1001);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_time", tm(), 32'h000);
        chk("t6_async_flags", flags(), 32'b0100);
        @(negedge clk);
        reset = 1'b0;
        btn_min = 1'b1;
        tick(20);
        btn_min = 1'b0;
        tick(3);
        chk("t6_hold_once", tm(), 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
